// File: rtl/ahb_sram_waitstate.sv
// AHB-Lite slave bridge to an asynchronous SRAM: programmable read/write wait states, wide accesses split into
// narrow SRAM beats, registered WE# pulse with setup/hold cycles, and a turnaround cycle on read-to-write.
module ahb_sram_waitstate #(
    parameter int W_DATA      = 32,
    parameter int W_ADDR      = 32,
    parameter int W_SRAM_DATA = 16,
    parameter int DEPTH       = 1 << 18,
    parameter int W_SRAM_ADDR = $clog2(DEPTH),
    parameter int RD_WAIT     = 1,
    parameter int WR_WAIT     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ahbls_hready_resp,
    input  logic                     ahbls_hready,
    output logic                     ahbls_hresp,
    input  logic [W_ADDR-1:0]        ahbls_haddr,
    input  logic                     ahbls_hwrite,
    input  logic [1:0]               ahbls_htrans,
    input  logic [2:0]               ahbls_hsize,
    input  logic [2:0]               ahbls_hburst,
    input  logic [3:0]               ahbls_hprot,
    input  logic                     ahbls_hmastlock,
    input  logic [W_DATA-1:0]        ahbls_hwdata,
    output logic [W_DATA-1:0]        ahbls_hrdata,
    output logic [W_SRAM_ADDR-1:0]   sram_addr,
    inout  wire  [W_SRAM_DATA-1:0]   sram_dq,
    output logic                     sram_ce_n,
    output logic                     sram_we_n,
    output logic                     sram_oe_n,
    output logic [W_SRAM_DATA/8-1:0] sram_byte_n
);

    localparam int NB   = W_SRAM_DATA / 8;
    localparam int BSEL = $clog2(NB);

    typedef enum logic [2:0] {IDLE, RD, RDDONE, TURN, WSETUP, WPULSE, WHOLD} state_t;

    state_t            state;
    logic              beat;
    logic              two_beats;
    logic [3:0]        cnt;
    logic [1:0]        addr_lo;
    logic [1:0]        size;
    logic [W_DATA-1:0] wdata;
    logic              dq_oe;
    logic              accept;
    logic              more;
    logic [31:0]       dq_ext;
    logic [31:0]       wsrc;
    logic [15:0]       half;
    logic [31:0]       dq32;
    logic              unused;

    assign ahbls_hresp = 1'b0;
    assign unused      = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hsize[2], ahbls_haddr};

    // hready_resp is high only in IDLE, RDDONE and the final WHOLD, exactly where a new address may be taken
    assign accept = ahbls_hready && ahbls_htrans[1] && ahbls_hready_resp;
    assign more   = two_beats && !beat;

    function automatic logic [NB-1:0] lanes_n(input logic [1:0] a, input logic [1:0] sz);
        logic [3:0] en;
        logic [1:0] off;
        off = 2'd0;
        en  = 4'b1111;
        case (sz)
            2'd0: begin
                off = a & 2'(NB - 1);
                en  = 4'b0001 << off;
            end
            2'd1: begin
                off = {a[1], 1'b0} & 2'(NB - 1);
                en  = 4'b0011 << off;
            end
            default: en = 4'b1111;
        endcase
        return ~en[NB-1:0];
    endfunction

    // First setup cycle drives straight from the bus so the latched copy is only needed from WPULSE on
    assign wsrc    = (state == WSETUP && !beat) ? ahbls_hwdata : wdata;
    assign half    = ((size == 2'd2) ? beat : addr_lo[1]) ? wsrc[31:16] : wsrc[15:0];
    assign dq32    = (W_SRAM_DATA == 16) ? {16'b0, half} : wsrc;
    assign sram_dq = dq_oe ? dq32[W_SRAM_DATA-1:0] : 'z;
    assign dq_ext  = 32'(sram_dq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            beat              <= 1'b0;
            two_beats         <= 1'b0;
            cnt               <= '0;
            addr_lo           <= '0;
            size              <= '0;
            wdata             <= '0;
            dq_oe             <= 1'b0;
            ahbls_hready_resp <= 1'b1;
            ahbls_hrdata      <= '0;
            sram_addr         <= '0;
            sram_ce_n         <= 1'b1;
            sram_we_n         <= 1'b1;
            sram_oe_n         <= 1'b1;
            sram_byte_n       <= '1;
        end else if (accept) begin
            addr_lo           <= ahbls_haddr[1:0];
            size              <= ahbls_hsize[1:0];
            two_beats         <= (W_SRAM_DATA == 16) && (ahbls_hsize[1:0] == 2'd2);
            beat              <= 1'b0;
            cnt               <= '0;
            sram_addr         <= ahbls_haddr[BSEL +: W_SRAM_ADDR];
            sram_we_n         <= 1'b1;
            ahbls_hready_resp <= 1'b0;
            if (!ahbls_hwrite) begin
                state       <= RD;
                sram_ce_n   <= 1'b0;
                sram_oe_n   <= 1'b0;
                sram_byte_n <= lanes_n(ahbls_haddr[1:0], ahbls_hsize[1:0]);
                dq_oe       <= 1'b0;
            end else if (state == RDDONE) begin
                state       <= TURN;
                sram_ce_n   <= 1'b1;
                sram_oe_n   <= 1'b1;
                sram_byte_n <= '1;
                dq_oe       <= 1'b0;
            end else begin
                state       <= WSETUP;
                sram_ce_n   <= 1'b0;
                sram_oe_n   <= 1'b1;
                sram_byte_n <= lanes_n(ahbls_haddr[1:0], ahbls_hsize[1:0]);
                dq_oe       <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: ;
                RD: begin
                    if (cnt == 4'(RD_WAIT)) begin
                        cnt <= '0;
                        if (W_SRAM_DATA == 16) begin
                            if (size == 2'd2) begin
                                if (beat) ahbls_hrdata[31:16] <= dq_ext[15:0];
                                else      ahbls_hrdata[15:0]  <= dq_ext[15:0];
                            end else begin
                                ahbls_hrdata <= {dq_ext[15:0], dq_ext[15:0]};
                            end
                        end else begin
                            ahbls_hrdata <= dq_ext;
                        end
                        if (more) begin
                            beat      <= 1'b1;
                            sram_addr <= sram_addr + 1'b1;
                        end else begin
                            state             <= RDDONE;
                            sram_ce_n         <= 1'b1;
                            sram_oe_n         <= 1'b1;
                            sram_byte_n       <= '1;
                            ahbls_hready_resp <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RDDONE: state <= IDLE;
                TURN: begin
                    state       <= WSETUP;
                    sram_ce_n   <= 1'b0;
                    sram_byte_n <= lanes_n(addr_lo, size);
                    dq_oe       <= 1'b1;
                end
                WSETUP: begin
                    state     <= WPULSE;
                    sram_we_n <= 1'b0;
                    cnt       <= '0;
                    if (!beat) wdata <= ahbls_hwdata;
                end
                WPULSE: begin
                    if (cnt == 4'(WR_WAIT)) begin
                        state     <= WHOLD;
                        sram_we_n <= 1'b1;
                        if (!more) ahbls_hready_resp <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WHOLD: begin
                    if (more) begin
                        state     <= WSETUP;
                        beat      <= 1'b1;
                        sram_addr <= sram_addr + 1'b1;
                    end else begin
                        state       <= IDLE;
                        sram_ce_n   <= 1'b1;
                        sram_byte_n <= '1;
                        dq_oe       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_waitstate.sv
// Bench for ahb_sram_waitstate: 16-bit SRAM model, AHB master driver pushing expectations, bus monitor popping them.
module tb_ahb_sram_waitstate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ahbls_hready_resp, ahbls_hready, ahbls_hresp, ahbls_hwrite;
    logic [31:0] ahbls_haddr  = 32'h0;
    logic [1:0]  ahbls_htrans = 2'b00;
    logic [2:0]  ahbls_hsize  = 3'd0;
    logic [2:0]  ahbls_hburst = 3'd0;
    logic [3:0]  ahbls_hprot  = 4'd0;
    logic        ahbls_hmastlock = 1'b0;
    logic [31:0] ahbls_hwdata = 32'h0;
    logic [31:0] ahbls_hrdata;
    logic [15:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_we_n, sram_oe_n;
    logic [1:0]  sram_byte_n;

    logic [15:0] mem [0:65535];
    logic [7:0]  shadow [0:255];

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] rdata;
        int          cyc;
        logic        trn;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int inv_bad = 0, idle_bad = 0, dp_cnt = 0;
    logic in_dp = 1'b0, turn_seen = 1'b0;
    logic [15:0] we_addr = 16'h0, rd_addr = 16'hffff;
    logic [1:0]  we_byten = 2'b11;

    assign ahbls_hready = ahbls_hready_resp;
    always #5 clk = ~clk;

    ahb_sram_waitstate #(
        .W_SRAM_DATA(16), .DEPTH(1 << 16), .RD_WAIT(1), .WR_WAIT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .ahbls_hready_resp(ahbls_hready_resp), .ahbls_hready(ahbls_hready), .ahbls_hresp(ahbls_hresp),
        .ahbls_haddr(ahbls_haddr), .ahbls_hwrite(ahbls_hwrite), .ahbls_htrans(ahbls_htrans),
        .ahbls_hsize(ahbls_hsize), .ahbls_hburst(ahbls_hburst), .ahbls_hprot(ahbls_hprot),
        .ahbls_hmastlock(ahbls_hmastlock), .ahbls_hwdata(ahbls_hwdata), .ahbls_hrdata(ahbls_hrdata),
        .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n), .sram_byte_n(sram_byte_n)
    );

    // Asynchronous SRAM: drives on CE#/OE# low, takes enabled lanes while WE# is low
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!rst && !sram_ce_n && !sram_we_n) begin
            if (!sram_byte_n[0]) mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!sram_byte_n[1]) mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_dp = 1'b0;
                sb.delete();
                continue;
            end
            if (!sram_we_n && sram_ce_n) inv_bad++;
            if (!sram_we_n && !sram_oe_n) inv_bad++;
            if (!sram_we_n) begin
                we_addr  = sram_addr;
                we_byten = sram_byte_n;
            end
            if (!sram_oe_n) rd_addr = sram_addr;
            if (in_dp) begin
                dp_cnt++;
                if (sram_ce_n && !ahbls_hready_resp) turn_seen = 1'b1;
                if (ahbls_hready_resp) begin
                    in_dp = 1'b0;
                    if (sb.size() == 0) begin
                        chk("unexpected_response", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_cycles"}, 32'(dp_cnt), 32'(e.cyc));
                        chk({e.name, "_turn"}, 32'(turn_seen), 32'(e.trn));
                        if (!e.wr) chk({e.name, "_rdata"}, ahbls_hrdata, e.rdata);
                    end
                end
            end else if (!ahbls_hready_resp || ahbls_hresp) begin
                idle_bad++;
            end
            if (ahbls_htrans[1] && ahbls_hready_resp) begin
                in_dp     = 1'b1;
                dp_cnt    = 0;
                turn_seen = 1'b0;
            end
        end
    end

    task automatic issue(input string nm, input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [31:0] rd, input int cyc, input logic trn);
        exp_t e;
        int n;
        e.name = nm; e.wr = w; e.rdata = rd; e.cyc = cyc; e.trn = trn;
        sb.push_back(e);
        ahbls_haddr = a; ahbls_hwrite = w; ahbls_hsize = sz; ahbls_htrans = 2'b10;
        n = 0;
        @(negedge clk);
        while (!ahbls_hready_resp && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ahbls_hwdata = wd;
        ahbls_htrans = 2'b00;
    endtask

    task automatic idle(input int n);
        ahbls_htrans = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_dp) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off, input logic [1:0] s);
        logic [7:0] h;
        if (s == 2'd2) return {shadow[off + 8'd3], shadow[off + 8'd2], shadow[off + 8'd1], shadow[off]};
        h = off & 8'hfe;
        return {shadow[h + 8'd1], shadow[h], shadow[h + 8'd1], shadow[h]};
    endfunction

    initial begin : stim
        int prev;
        for (int k = 0; k < 256; k++) shadow[k] = 8'(k * 7 + 3);
        for (int k = 0; k < 128; k++) mem[16'h100 + 16'(k)] = {shadow[8'(2 * k + 1)], shadow[8'(2 * k)]};
        mem[16'h80] = 16'h1234; mem[16'h81] = 16'hABCD;
        mem[16'h1]  = 16'h1122; mem[16'h9]  = 16'h0000;
        mem[16'h0]  = 16'hCAFE; mem[16'h2]  = 16'h3344;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_hready_resp", 32'(ahbls_hready_resp), 32'd1);
        chk("rst_hrdata", ahbls_hrdata, 32'h0);
        chk("rst_strobes", {29'b0, sram_ce_n, sram_we_n, sram_oe_n}, 32'h7);
        chk("rst_byte_n", 32'(sram_byte_n), 32'h3);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_hresp", 32'(ahbls_hresp), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        issue("word_read", 32'h100, 1'b0, 3'd2, 32'h0, 32'hABCD1234, 5, 1'b0);
        drain();
        idle(2);
        issue("word_write", 32'h8, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 8, 1'b0);
        drain();
        chk("word_write_lo", {16'h0, mem[16'h4]}, 32'hBEEF);
        chk("word_write_hi", {16'h0, mem[16'h5]}, 32'hDEAD);

        issue("byte_write", 32'h3, 1'b1, 3'd0, 32'h55000000, 32'h0, 4, 1'b0);
        drain();
        chk("byte_write_addr", 32'(we_addr), 32'h1);
        chk("byte_write_byte_n", 32'(we_byten), 32'h1);
        chk("byte_write_mem", {16'h0, mem[16'h1]}, 32'h5522);

        issue("rd_before_turn", 32'h100, 1'b0, 3'd2, 32'h0, 32'hABCD1234, 5, 1'b0);
        issue("wr_after_read", 32'h12, 1'b1, 3'd1, 32'h77770000, 32'h0, 5, 1'b1);
        drain();
        chk("half_write_mem", {16'h0, mem[16'h9]}, 32'h7777);

        issue("wr_before_read", 32'h20, 1'b1, 3'd2, 32'h0BADF00D, 32'h0, 8, 1'b0);
        issue("rd_after_write", 32'h20, 1'b0, 3'd2, 32'h0, 32'h0BADF00D, 5, 1'b0);
        drain();

        ahbls_htrans = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        idle(2);
        issue("wrap_read", 32'h40000, 1'b0, 3'd1, 32'h0, 32'hCAFECAFE, 3, 1'b0);
        drain();
        chk("wrap_addr", 32'(rd_addr), 32'h0);
        idle(1);
        issue("byte_read", 32'h5, 1'b0, 3'd0, 32'h0, 32'h33443344, 3, 1'b0);
        drain();

        prev = 0;
        for (int i = 0; i < 24; i++) begin
            logic w;
            logic [1:0] s;
            logic [7:0] off;
            logic [31:0] wd, rexp;
            int beats, cyc;
            logic trn;
            w    = 1'($urandom_range(0, 1));
            s    = 2'($urandom_range(0, 2));
            off  = 8'($urandom_range(0, 255));
            off  = off & ~((8'd1 << s) - 8'd1);
            wd   = $urandom;
            rexp = 32'h0;
            beats = (s == 2'd2) ? 2 : 1;
            trn  = w && (prev == 1);
            if (w) begin
                cyc = beats * 4 + (trn ? 1 : 0);
                for (int b = 0; b < (1 << s); b++)
                    shadow[off + 8'(b)] = 8'(wd >> (8 * ((int'(off) + b) % 4)));
            end else begin
                cyc  = beats * 2 + 1;
                rexp = model_read(off, s);
            end
            issue("rand", 32'h200 + {24'h0, off}, w, {1'b0, s}, wd, rexp, cyc, trn);
            prev = w ? 2 : 1;
            if ($urandom_range(0, 3) == 0) begin
                drain();
                idle(1);
                prev = 0;
            end
        end
        drain();

        ahbls_haddr = 32'h30; ahbls_hwrite = 1'b1; ahbls_hsize = 3'd2; ahbls_htrans = 2'b10;
        @(negedge clk);
        @(posedge clk);
        #1;
        ahbls_hwdata = 32'h12345678;
        ahbls_htrans = 2'b00;
        @(posedge clk);
        #3;
        chk("we_low_before_reset", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("midreset_we_n", 32'(sram_we_n), 32'd1);
        chk("midreset_ce_n", 32'(sram_ce_n), 32'd1);
        chk("midreset_oe_n", 32'(sram_oe_n), 32'd1);
        chk("midreset_hready_resp", 32'(ahbls_hready_resp), 32'd1);
        chk("midreset_hrdata", ahbls_hrdata, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        issue("read_after_reset", 32'h100, 1'b0, 3'd2, 32'h0, 32'hABCD1234, 5, 1'b0);
        drain();
        idle(2);

        chk("strobe_invariant", 32'(inv_bad), 32'd0);
        chk("idle_zero_wait", 32'(idle_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_waitstate.md
Name: ahb_sram_waitstate

Overview:
AHB-Lite slave bridge to an external asynchronous SRAM, with programmable read/write wait states and support for an SRAM narrower than the bus. Unlike the zero-wait bridge, it stalls the bus with hready_resp and splits wide accesses into several SRAM beats. It drives a registered WE# pulse with setup/hold margin and inserts a bus-turnaround cycle between reads and writes. It sits between the system AHB-Lite interconnect and the board SRAM pins.

Parameters:
W_DATA, 32, AHB data width (32 only)
W_ADDR, 32, AHB address width
W_SRAM_DATA, 16, SRAM data width: 16 or 32
DEPTH, 1<<18, SRAM depth in W_SRAM_DATA words
W_SRAM_ADDR, $clog2(DEPTH), SRAM address width (left at default)
RD_WAIT, 1, extra cycles per read beat (0..15)
WR_WAIT, 1, extra cycles of WE# low per write beat (0..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
ahbls_hready_resp  output  1  slave ready; low stalls the data phase
ahbls_hready  input  1  bus ready
ahbls_hresp  output  1  always 0 (OKAY)
ahbls_haddr  input  W_ADDR  address
ahbls_hwrite  input  1  write flag
ahbls_htrans  input  2  transfer type
ahbls_hsize  input  3  transfer size: 0, 1 or 2
ahbls_hburst  input  3  unused
ahbls_hprot  input  4  unused
ahbls_hmastlock  input  1  unused
ahbls_hwdata  input  W_DATA  write data
ahbls_hrdata  output  W_DATA  read data (registered)
sram_addr  output  W_SRAM_ADDR  SRAM word address
sram_dq  inout  W_SRAM_DATA  SRAM data; tristated except in write states
sram_ce_n  output  1  chip enable, active low
sram_we_n  output  1  write enable, active low, registered
sram_oe_n  output  1  output enable, active low
sram_byte_n  output  W_SRAM_DATA/8  byte lane enables, active low

Behaviour:
- Reset (async, any state): state IDLE. hready_resp=1, hrdata=0, ce_n/we_n/oe_n=1, byte_n all 1, dq released, sram_addr=0.
- Address phase accept: hready & htrans[1] in IDLE. Register addr, size and write flag; compute beat count.
  - Beats = 2 when W_SRAM_DATA=16 and hsize=2, otherwise 1.
  - Low address bits below the size are ignored; unaligned accesses are treated as aligned.
- IDLE/BUSY transfers and hready=0 cycles are ignored. The bridge returns zero-wait OKAY for them.
- Address mapping: sram_addr = haddr[log2(W_SRAM_DATA/8) +: W_SRAM_ADDR]. Upper bits are ignored, so addresses wrap modulo DEPTH. Beat 1 uses sram_addr+1 (lower halfword first).
- byte_n: lanes come from size and the low address bits within the SRAM word. Word beats in 16-bit mode enable both lanes.
- States: IDLE, RD, RDDONE, TURN, WSETUP, WPULSE, WHOLD.
- RD:
  - ce_n=0, oe_n=0 for RD_WAIT+1 cycles per beat.
  - Data is captured into hrdata on the last cycle of each beat.
    - 16-bit mode, word access: beat 0 loads hrdata[15:0], beat 1 loads hrdata[31:16].
    - 16-bit mode, sub-word access: the halfword is replicated on both halves.
  - After the final beat, go to RDDONE.
- RDDONE: oe_n=1, ce_n=1, hready_resp=1, hrdata valid.
  - Read data phase = beats*(RD_WAIT+1)+1 cycles.
- WSETUP (1 cycle): ahbls_hwdata is latched (first data-phase cycle only). dq is driven with the beat's lane, ce_n=0, we_n=1.
- WPULSE: we_n=0 for WR_WAIT+1 cycles.
- WHOLD (1 cycle): we_n=1, dq still driven, ce_n=0.
  - If another beat remains, go to WSETUP for beat 1.
  - Otherwise hready_resp=1 in this cycle.
  - Write data phase = beats*(WR_WAIT+3) cycles.
- hready_resp is 0 in every data-phase cycle except the last one (RDDONE, or the final WHOLD).
- Pipelining: a new address phase is accepted in the final data-phase cycle. The next state is entered directly, with no IDLE cycle.
- Turnaround:
  - A write accepted while completing a read enters TURN (1 cycle, all strobes high, dq released) before WSETUP; this adds 1 cycle to that write's data phase.
  - Write-to-read needs no TURN, because dq is released on leaving WHOLD.
- Invariant: dq is never driven while oe_n=0, and we_n=0 only while ce_n=0.

Test Plan:
- W_SRAM_DATA=16, RD_WAIT=1; word read at 0x100, SRAM[0x80]=0x1234, [0x81]=0xABCD -> hready_resp low 4 cycles, then high with hrdata=0xABCD1234.
- Word write 0xDEADBEEF at 0x8, WR_WAIT=1 -> two beats, each 1 setup + 2 WE-low + 1 hold cycles. SRAM[4]=0xBEEF, [5]=0xDEAD; data phase is 8 cycles.
- Byte write 0x55 at 0x3 (16-bit mode) -> single beat, sram_addr=1, byte_n=2'b01, only the upper byte changes.
- Back-to-back read then write -> TURN cycle observed. dq is never driven while oe_n=0, checked by an assertion over random traffic.
- Address 0x40000 with DEPTH=1<<16, 16-bit mode -> wraps to sram_addr=0. IDLE transfers in between -> zero-wait OKAY.
- Assert rst during WPULSE -> same cycle: we_n=1, ce_n=1, dq released, hready_resp=1. After release, a new read completes normally.
